gpio_cfg_regfile: RTL and testbench

GPIO_CFG_REGFILE -- requirements
Module: gpio_cfg_regfile

---
 rtl/gpio_cfg_regfile.sv | 131 +++++++++++++
 tb/tb_gpio_cfg_regfile.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/gpio_cfg_regfile.sv
// GPIO-bus configuration register file: synchronises a slow asynchronous write bus,
// decodes triggers, shifting config registers, readback snapshots and error counting.
// Optional shadow/commit staging of config registers is enabled by defining CFG_SHADOW_EN.
module gpio_cfg_regfile #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int REG_W       = 32,
  parameter int NUM_REGS    = 20,
  parameter int TRIG_N      = 2,
  parameter int RB_BASE     = 16'h0100,
  parameter int RB_N        = 4,
  parameter int COMMIT_ADDR = 16'hFFFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W+DATA_W:0]       gpio_in,
  input  logic [RB_N*REG_W-1:0]        rb_in,
  output logic [NUM_REGS*REG_W-1:0]    cfg_o,
  output logic [TRIG_N-1:0]            trig_o,
  output logic [REG_W-1:0]             rd_data,
  output logic                         rd_valid,
  output logic [7:0]                   err_cnt
);

  localparam int NCFG = NUM_REGS - TRIG_N;
  localparam int AD_W = ADDR_W + DATA_W;

  logic              r_s1, r_s2, r_s3;
  logic [AD_W-1:0]   r_ad1, r_ad2;
  logic [1:0]        r_fill;
  logic              r_stb;
  logic [ADDR_W-1:0] r_wa;
  logic [DATA_W-1:0] r_wd;
  logic [REG_W-1:0]  r_act [NCFG];
`ifdef CFG_SHADOW_EN
  logic [REG_W-1:0]  r_shd [NCFG];
`endif

  logic w_stb, w_is_trig, w_is_cfg, w_is_rb, w_is_cmt;

  // Strobe is held off until every synchroniser stage holds a post-reset sample,
  // so a w_clk already high at reset release is not mistaken for a rising edge.
  assign w_stb = r_s2 & ~r_s3 & (r_fill == 2'd3);

  assign w_is_trig = (r_wa < ADDR_W'(TRIG_N));
  assign w_is_cfg  = !w_is_trig && (r_wa < ADDR_W'(NUM_REGS));
  assign w_is_rb   = (r_wa >= ADDR_W'(RB_BASE)) && (r_wa < ADDR_W'(RB_BASE + RB_N));
  assign w_is_cmt  = (r_wa == ADDR_W'(COMMIT_ADDR));

  function automatic logic [REG_W-1:0] f_shift(input logic [REG_W-1:0] v,
                                               input logic [DATA_W-1:0] d);
    return (v << DATA_W) | REG_W'(d);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_ad1  <= '0;
      r_ad2  <= '0;
      r_fill <= 2'd0;
      r_stb  <= 1'b0;
      r_wa   <= '0;
      r_wd   <= '0;
    end else begin
      r_s1  <= gpio_in[AD_W];
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_ad1 <= gpio_in[AD_W-1:0];
      r_ad2 <= r_ad1;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
      r_stb <= w_stb;
      r_wa  <= r_ad2[ADDR_W-1:0];
      r_wd  <= r_ad2[ADDR_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_o   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err_cnt  <= 8'd0;
      for (int i = 0; i < NCFG; i++) begin
        r_act[i] <= '0;
`ifdef CFG_SHADOW_EN
        r_shd[i] <= '0;
`endif
      end
    end else begin
      trig_o   <= '0;
      rd_valid <= 1'b0;
      if (r_stb) begin
        if (w_is_trig) begin
          for (int t = 0; t < TRIG_N; t++)
            if (r_wa == ADDR_W'(t)) trig_o[t] <= 1'b1;
        end else if (w_is_cfg) begin
          for (int i = 0; i < NCFG; i++)
            if (r_wa == ADDR_W'(i + TRIG_N)) begin
`ifdef CFG_SHADOW_EN
              r_shd[i] <= f_shift(r_shd[i], r_wd);
`else
              r_act[i] <= f_shift(r_act[i], r_wd);
`endif
            end
        end else if (w_is_rb) begin
          for (int k = 0; k < RB_N; k++)
            if (r_wa == ADDR_W'(RB_BASE + k)) rd_data <= rb_in[k*REG_W +: REG_W];
          rd_valid <= 1'b1;
        end else if (w_is_cmt) begin
`ifdef CFG_SHADOW_EN
          for (int i = 0; i < NCFG; i++) r_act[i] <= r_shd[i];
`endif
        end else if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  // Trigger addresses have no storage; their cfg_o lanes are tied low.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_lane
    if (g < TRIG_N) begin : g_trig
      assign cfg_o[g*REG_W +: REG_W] = '0;
    end else begin : g_cfg
      assign cfg_o[g*REG_W +: REG_W] = r_act[g-TRIG_N];
    end
  end

endmodule

// File: tb/tb_gpio_cfg_regfile.sv
// Self-checking bench for gpio_cfg_regfile: directed scenarios plus randomized writes
// checked against an address-map level reference model (honours CFG_SHADOW_EN).
module tb_gpio_cfg_regfile;
  localparam int AW = 16, DW = 8, RW = 32, NR = 20, TN = 2;
  localparam int RBB = 16'h0100, RBN = 4, CA = 16'hFFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [AW+DW:0]    gpio_in = '0;
  logic [RBN*RW-1:0] rb_in = '0;
  logic [NR*RW-1:0]  cfg_o;
  logic [TN-1:0]     trig_o;
  logic [RW-1:0]     rd_data;
  logic              rd_valid;
  logic [7:0]        err_cnt;

  gpio_cfg_regfile #(.ADDR_W(AW), .DATA_W(DW), .REG_W(RW), .NUM_REGS(NR), .TRIG_N(TN),
                     .RB_BASE(RBB), .RB_N(RBN), .COMMIT_ADDR(CA)) dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .rb_in(rb_in), .cfg_o(cfg_o),
    .trig_o(trig_o), .rd_data(rd_data), .rd_valid(rd_valid), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, n_trig = 0, n_rdv = 0;
  longint m_act [NR];
  longint m_shd [NR];
  longint m_rbv [RBN];
  longint m_rd;
  int     m_err;

  always @(negedge clk) begin
    if (trig_o != '0) n_trig++;
    if (rd_valid) n_rdv++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin m_act[i] = 0; m_shd[i] = 0; end
    m_rd = 0; m_err = 0;
  endtask

  task automatic set_rb(input int k, input longint v);
    m_rbv[k] = v;
    rb_in[k*RW +: RW] = RW'(v);
  endtask

  task automatic check_state(input string ph, input logic [TN-1:0] et, input logic ev);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_cfg%0d", ph, i), 64'(cfg_o[i*RW +: RW]), 64'(m_act[i]));
    chk({ph, "_trig"}, 64'(trig_o), 64'(et));
    chk({ph, "_rdv"}, 64'(rd_valid), 64'(ev));
    chk({ph, "_rd"}, 64'(rd_data), 64'(m_rd));
    chk({ph, "_err"}, 64'(err_cnt), 64'(m_err));
  endtask

  // One GPIO write: w_clk rises with addr/data, held high for 'hold' extra cycles, then falls.
  task automatic wr(input int a, input int d, input int hold);
    int t0, r0;
    bit it, ic, ir, im;
    logic [TN-1:0] et;
    it = a < TN;
    ic = !it && a < NR;
    ir = a >= RBB && a < RBB + RBN;
    im = a == CA;
    et = '0;
    if (it) et[a] = 1'b1;
    @(negedge clk);
    gpio_in = {1'b1, DW'(d), AW'(a)};
    t0 = n_trig; r0 = n_rdv;
    repeat (3) @(posedge clk);
    #1 check_state("pre", '0, 1'b0);
    if (ic) begin
`ifdef CFG_SHADOW_EN
      m_shd[a] = (m_shd[a] * 256 + longint'(d)) % 64'h1_0000_0000;
`else
      m_act[a] = (m_act[a] * 256 + longint'(d)) % 64'h1_0000_0000;
`endif
    end else if (ir) begin
      m_rd = m_rbv[a-RBB];
    end else if (im) begin
`ifdef CFG_SHADOW_EN
      for (int i = 0; i < NR; i++) m_act[i] = m_shd[i];
`endif
    end else if (!it) begin
      if (m_err < 255) m_err++;
    end
    @(posedge clk);
    #1 check_state("post", et, ir);
    @(posedge clk);
    #1 chk("pulse_end_trig", 64'(trig_o), 64'd0);
    chk("pulse_end_rdv", 64'(rd_valid), 64'd0);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    gpio_in[AW+DW] = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_state("fall", '0, 1'b0);
    chk("trig_pulses", 64'(n_trig - t0), 64'(it ? 1 : 0));
    chk("rdv_pulses", 64'(n_rdv - r0), 64'(ir ? 1 : 0));
  endtask

  initial begin
    int a, t0, r0;
    model_reset();
    for (int k = 0; k < RBN; k++) set_rb(k, longint'($urandom));
    set_rb(2, 64'hDEADBEEF);
    #1 check_state("reset", '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Shift writes into lane 2
    wr(2, 8'hAB, 0);
    wr(2, 8'hCD, 0);
    // Trigger with w_clk held high for 20 cycles
    wr(1, 8'h5A, 20);
    wr(0, 8'h00, 2);
    // Readback channel 2
    wr(16'h0102, 8'h33, 1);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0: a = int'($urandom_range(0, NR - 1));
        1: a = RBB + int'($urandom_range(0, RBN - 1));
        2: a = CA;
        default: a = ($urandom_range(0, 1) != 0) ? int'($urandom_range(NR, RBB - 1))
                                                 : int'($urandom_range(16'h0200, 16'hFFFE));
      endcase
      set_rb(int'($urandom_range(0, RBN - 1)), longint'($urandom));
      wr(a, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    // Error counter saturation, then commit is not an error
    for (int n = 0; n < 300; n++) wr(16'h0050, n & 255, 0);
    chk("err_sat", 64'(err_cnt), 64'd255);
    wr(CA, 8'h00, 0);
    chk("err_after_commit", 64'(err_cnt), 64'd255);

    // Shadow staging (direct write when the shadow feature is off)
    wr(3, 8'h11, 0);
    wr(CA, 8'h00, 0);
    chk("lane3_after_commit", 64'(cfg_o[3*RW +: RW]),
        64'(m_act[3]));

    // Reset mid-flight, then release with w_clk still high
    @(negedge clk);
    gpio_in = {1'b1, 8'h55, 16'd4};
    t0 = n_trig; r0 = n_rdv;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1 check_state("rst_async", '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_state("rst_release_high", '0, 1'b0);
    chk("rst_no_trig", 64'(n_trig - t0), 64'd0);
    chk("rst_no_rdv", 64'(n_rdv - r0), 64'd0);
    @(negedge clk);
    gpio_in[AW+DW] = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_state("rst_fall", '0, 1'b0);
    wr(4, 8'h77, 0);
    wr(1, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
